// File: rtl/cpu_clk_en_ctrl.sv
// CPU clock-enable generator: single-step button, two divided rates, full speed, halt.
// Define CPU_CLK_BURST_EN to make each button press issue burstLen+1 enables.
module cpu_clk_en_ctrl #(
  parameter int unsigned DIV_W      = 24,
  parameter int unsigned DEB_CYCLES = 65535,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btnN,
  input  logic [1:0]       modeSel,
  input  logic [DIV_W-1:0] divSlow,
  input  logic [DIV_W-1:0] divFast,
  input  logic [3:0]       burstLen,
  input  logic             halt,
  output logic             cpuClkEn,
  output logic             running,
  output logic [CNT_W-1:0] enCount,
  output logic             btnDb
);

  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {
    STEP_IDLE = 2'd0,
    BURST     = 2'd1,
    RUN_DIV   = 2'd2,
    RUN_FULL  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_btn_db;
  logic             r_press;
  logic [1:0]       r_mode_prev;
  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_cnt_nxt;
  logic [3:0]       r_burst_cnt;
  logic [3:0]       w_burst_cnt_nxt;
  logic [3:0]       w_burst_load;
  logic [DIV_W-1:0] w_div_sel;
  logic             w_mode_chg;
  logic             w_en;
  logic             r_cpu_clk_en;
  logic             r_running;
  logic [CNT_W-1:0] r_en_cnt;

`ifdef CPU_CLK_BURST_EN
  assign w_burst_load = burstLen;
`else
  logic w_unused_burst_len;
  assign w_unused_burst_len = ^burstLen;
  assign w_burst_load       = 4'd0;
`endif

  assign w_mode_chg = (modeSel != r_mode_prev);
  assign w_div_sel  = modeSel[1] ? divFast : divSlow;

  // Synchroniser and debouncer; r_press marks the cycle btnDb first reads 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_deb_cnt <= '0;
      r_btn_db  <= 1'b1;
      r_press   <= 1'b0;
    end else begin
      r_sync1 <= btnN;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_btn_db) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        r_deb_cnt <= '0;
        r_btn_db  <= r_sync2;
        r_press   <= ~r_sync2;
      end else begin
        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= STEP_IDLE;
      r_mode_prev <= 2'b00;
      r_div_cnt   <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode_prev <= modeSel;
      r_div_cnt   <= w_div_cnt_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Next state and enable decision; a mode change wins over halt and kills the enable
  always_comb begin
    w_state_nxt     = r_state;
    w_div_cnt_nxt   = r_div_cnt;
    w_burst_cnt_nxt = r_burst_cnt;
    w_en            = 1'b0;
    if (w_mode_chg) begin
      w_div_cnt_nxt   = '0;
      w_burst_cnt_nxt = '0;
      case (modeSel)
        2'b00:   w_state_nxt = STEP_IDLE;
        2'b11:   w_state_nxt = RUN_FULL;
        default: w_state_nxt = RUN_DIV;
      endcase
    end else if (!halt) begin
      case (r_state)
        STEP_IDLE: begin
          if (r_press) begin
            w_burst_cnt_nxt = w_burst_load;
            w_state_nxt     = BURST;
          end
        end
        BURST: begin
          w_en = 1'b1;
          if (r_burst_cnt == 4'd0) begin
            w_state_nxt = STEP_IDLE;
          end else begin
            w_burst_cnt_nxt = r_burst_cnt - 4'd1;
          end
        end
        RUN_DIV: begin
          if (r_div_cnt >= w_div_sel) begin
            w_en          = 1'b1;
            w_div_cnt_nxt = '0;
          end else begin
            w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
          end
        end
        RUN_FULL: w_en = 1'b1;
        default:  w_state_nxt = STEP_IDLE;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpu_clk_en <= 1'b0;
      r_running    <= 1'b0;
      r_en_cnt     <= '0;
    end else begin
      r_cpu_clk_en <= w_en;
      r_running    <= (modeSel != 2'b00) && !halt;
      r_en_cnt     <= r_en_cnt + CNT_W'(w_en);
    end
  end

  assign cpuClkEn = r_cpu_clk_en;
  assign running  = r_running;
  assign enCount  = r_en_cnt;
  assign btnDb    = r_btn_db;

endmodule

// File: tb/tb_cpu_clk_en_ctrl.sv
// Self-checking bench for cpu_clk_en_ctrl against a cycle-level behavioural model.
// Honours CPU_CLK_BURST_EN the same way the design does.
module tb_cpu_clk_en_ctrl;

  localparam int DIV_W = 8;
  localparam int DEB   = 4;
  localparam int CNT_W = 4;

`ifdef CPU_CLK_BURST_EN
  localparam int EXP_B4    = 4;
  localparam int EXP_B13   = 13;
  localparam int EXP_CNT   = 2;
  localparam int EXP_PRE   = 2;
  localparam int EXP_POST  = 8;
`else
  localparam int EXP_B4    = 1;
  localparam int EXP_B13   = 2;
  localparam int EXP_CNT   = 4;
  localparam int EXP_PRE   = 1;
  localparam int EXP_POST  = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             btnN;
  logic [1:0]       modeSel;
  logic [DIV_W-1:0] divSlow;
  logic [DIV_W-1:0] divFast;
  logic [3:0]       burstLen;
  logic             halt;
  logic             cpuClkEn;
  logic             running;
  logic [CNT_W-1:0] enCount;
  logic             btnDb;

  cpu_clk_en_ctrl #(.DIV_W(DIV_W), .DEB_CYCLES(DEB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .btnN(btnN), .modeSel(modeSel), .divSlow(divSlow),
    .divFast(divFast), .burstLen(burstLen), .halt(halt), .cpuClkEn(cpuClkEn),
    .running(running), .enCount(enCount), .btnDb(btnDb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int lowc = 0;

  // Model state: hist[j] is btnN as sampled j+1 edges ago
  bit         m_en, m_run, m_db, m_press_pend;
  int         m_cnt, m_elapsed, m_left;
  logic [1:0] m_prev_mode;
  bit         hist [0:DEB];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_run = 0; m_db = 1; m_press_pend = 0;
    m_cnt = 0; m_elapsed = 0; m_left = 0; m_prev_mode = 2'b00;
    for (int i = 0; i <= DEB; i++) hist[i] = 1'b1;
  endtask

  task automatic model_edge();
    bit flip, press_now, chg;
    int div;
    if (rst) begin
      model_reset();
      return;
    end
    flip = 1;
    for (int i = 1; i <= DEB; i++) if (hist[i] == m_db) flip = 0;
    for (int i = DEB; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = btnN;
    press_now    = m_press_pend;
    m_press_pend = 0;
    if (flip) begin
      m_db = !m_db;
      m_press_pend = !m_db;
    end
    chg = (modeSel != m_prev_mode);
    m_prev_mode = modeSel;
    m_en = 0;
    if (chg) begin
      m_elapsed = 0;
      m_left = 0;
    end else if (!halt) begin
      case (modeSel)
        2'b00: begin
          if (m_left > 0) begin
            m_en = 1;
            m_left--;
          end else if (press_now) begin
`ifdef CPU_CLK_BURST_EN
            m_left = int'(burstLen) + 1;
`else
            m_left = 1;
`endif
          end
        end
        2'b11: m_en = 1;
        default: begin
          div = (modeSel == 2'b01) ? int'(divSlow) : int'(divFast);
          if (m_elapsed >= div) begin
            m_en = 1;
            m_elapsed = 0;
          end else begin
            m_elapsed++;
          end
        end
      endcase
    end
    m_run = (modeSel != 2'b00) && !halt;
    m_cnt = (m_cnt + int'(m_en)) % (1 << CNT_W);
  endtask

  // One clock: advance the model at the edge, compare all outputs just after it
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("cpuClkEn", int'(cpuClkEn), int'(m_en));
    chk("running",  int'(running),  int'(m_run));
    chk("enCount",  int'(enCount),  m_cnt);
    chk("btnDb",    int'(btnDb),    int'(m_db));
    if (cpuClkEn) pulses++;
  endtask

  initial begin
    bit bounce [6];
    rst = 1'b1; btnN = 1'b1; modeSel = 2'b00; divSlow = '0; divFast = '0;
    burstLen = 4'd0; halt = 1'b0;
    model_reset();
    #2;
    chk("rst_cpuClkEn", int'(cpuClkEn), 0);
    chk("rst_running",  int'(running),  0);
    chk("rst_enCount",  int'(enCount),  0);
    chk("rst_btnDb",    int'(btnDb),    1);
    step(); step();
    rst = 1'b0;

    // Bouncy press, then stable low and release: one enable
    bounce = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      btnN = bounce[i];
      step();
    end
    btnN = 1'b0; repeat (10) step();
    btnN = 1'b1; repeat (10) step();
    chk("deb_one_pulse", pulses, 1);
    chk("deb_encount", int'(enCount), 1);

    // Short burst
    burstLen = 4'd3; pulses = 0;
    btnN = 1'b0; repeat (8) step();
    btnN = 1'b1; repeat (10) step();
    chk("burst4_pulses", pulses, EXP_B4);

    // Long burst with a second press arriving mid-burst
    burstLen = 4'd12; pulses = 0;
    btnN = 1'b0; repeat (6) step();
    btnN = 1'b1; repeat (6) step();
    btnN = 1'b0; repeat (8) step();
    btnN = 1'b1; repeat (12) step();
    chk("burst13_pulses", pulses, EXP_B13);
    chk("burst_encount", int'(enCount), EXP_CNT);

    // Slow rate then fast rate with divFast=0
    modeSel = 2'b01; divSlow = 8'd9; pulses = 0;
    step();
    chk("slow_chg_no_pulse", int'(cpuClkEn), 0);
    repeat (30) step();
    chk("slow_pulses", pulses, 3);
    modeSel = 2'b10; divFast = 8'd0; pulses = 0;
    step();
    chk("fast_chg_no_pulse", int'(cpuClkEn), 0);
    repeat (5) step();
    chk("fast_every", pulses, 5);

    // Divisor lowered below the running count
    modeSel = 2'b01; divSlow = 8'd200;
    step(); repeat (20) step();
    divSlow = 8'd5;
    step();
    chk("div_reduce", int'(cpuClkEn), 1);
    pulses = 0;
    repeat (12) step();
    chk("div_reduce_period", pulses, 2);

    // Full speed with a 5-cycle halt
    modeSel = 2'b11;
    step(); repeat (3) step();
    halt = 1'b1; pulses = 0; lowc = 0;
    repeat (5) begin
      step();
      if (!cpuClkEn && !running) lowc++;
    end
    halt = 1'b0;
    chk("halt_low", lowc, 5);
    chk("halt_pulses", pulses, 0);
    step();
    chk("halt_resume", int'(cpuClkEn), 1);

    // Counter wrap from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    pulses = 0;
    repeat (15) step();
    chk("wrap_15", int'(enCount), 15);
    step();
    chk("wrap_0", int'(enCount), 0);
    chk("wrap_pulses", pulses, 16);

    // Reset mid-burst, then a press held through reset is still seen
    modeSel = 2'b00;
    step();
    burstLen = 4'd7; btnN = 1'b0; pulses = 0;
    for (int i = 0; i < 40 && pulses < EXP_PRE; i++) step();
    chk("pre_rst_pulses", pulses, EXP_PRE);
    rst = 1'b1;
    #1;
    chk("midrst_cpuClkEn", int'(cpuClkEn), 0);
    chk("midrst_running",  int'(running),  0);
    chk("midrst_enCount",  int'(enCount),  0);
    chk("midrst_btnDb",    int'(btnDb),    1);
    step(); step();
    rst = 1'b0; pulses = 0;
    repeat (20) step();
    chk("post_rst_press", pulses, EXP_POST);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
